ram_recorder: RTL and testbench
===============================

# ram_recorder

Parametrised record/playback controller with an internal synchronous RAM, driven by single-cycle button pulses from the existing pulse generator. Extends the single-address toggle-write scheme to a full address sweep: one button records a stream of `din` samples at a fixed step rate, another replays them on `dout`. Sits between the board pulse generators (inputs) and the LED/display drivers (outputs).

## Interface
- `DATA_W`, 4, sample width
- `ADDR_W`, 5, address width
- `DEPTH`, 32, usable entries; 1 ≤ DEPTH ≤ 2**ADDR_W
- `STEP_DIV`, 1, clock cycles per sample step; ≥ 1
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `rec_pulse`  in  1  one-cycle pulse: start/stop recording
- `play_pulse`  in  1  one-cycle pulse: start/stop playback
- `din`  in  DATA_W  sample to record
- `dout`  out  DATA_W  registered playback data
- `weout`  out  1  high while in RECORD
- `busy`  out  1  high in RECORD or PLAY
- `addr`  out  ADDR_W  current RAM address
- `len`  out  ADDR_W+1  number of valid recorded samples
- `done`  out  1  one-cycle pulse at end of recording or playback

## Operation
- States: IDLE, RECORD, PLAY. Reset → IDLE.
- Step divider: counter 0..STEP_DIV-1, cleared on every state entry; `tick` is internal, high when counter == STEP_DIV-1.
- IDLE:
  - `rec_pulse` → RECORD; `addr`←0, `len`←0.
  - `play_pulse` with `len`>0 → PLAY; `addr`←0. With `len`==0: ignored.
  - Both pulses in the same cycle: `rec_pulse` wins.
- RECORD, on `tick`: mem[`addr`]←`din`, `addr`++, `len`++.
  - `len` reaching DEPTH on that tick → IDLE, `done`=1.
  - `rec_pulse` → IDLE, `done`=1. Samples already written are kept.
  - `rec_pulse` coinciding with `tick`: the write occurs, then → IDLE.
  - `play_pulse` ignored.
- PLAY, on `tick`: `dout`←mem[`addr`] (synchronous read).
  - `addr`==`len`-1 → end of sequence; see Configuration.
  - Otherwise `addr`++.
  - `play_pulse` → IDLE with no `done`; `dout` holds its last value.
  - `rec_pulse` ignored.
- `addr` stays unchanged in IDLE. `len` persists until the next RECORD entry.
- RAM contents are not reset and survive `rst_n`; `len` is reset to 0, so the contents become unreachable.
- `weout` = (state==RECORD). Writes occur only on `tick`.

## Timing
- All outputs are registered. Reset values: `dout`=0, `weout`=0, `busy`=0, `addr`=0, `len`=0, `done`=0. Divider=0.
- A pulse sampled at edge N changes state at edge N. `weout` and `busy` are valid after edge N.
- First step occurs STEP_DIV edges after entry. With STEP_DIV=1 there is one step every cycle, starting at the edge after entry.
- Write: the `din` sampled at the tick edge is stored.
- Read latency: `dout` shows mem[`addr`] after the tick edge, which is one cycle after `addr` is presented.
- `done` is high for exactly one cycle, in the cycle after the transition to IDLE.
- Asserting `rst_n` mid-RECORD or mid-PLAY gives immediate IDLE with all outputs at their reset values. No pending write completes.

## Configuration
- `RAM_RECORDER_LOOP_PLAY_EN` defined: at end of sequence `addr` wraps to 0 and PLAY continues indefinitely. Only `play_pulse` or reset leaves PLAY, and `done` is never raised from PLAY.
- Undefined: at end of sequence → IDLE, `done`=1. `addr` holds `len`-1 and `dout` holds the last sample.

## Test plan
- Reset: assert `rst_n`=0 mid-PLAY → all outputs 0 immediately. Release, then `play_pulse` → ignored (`len`=0, `busy` stays 0).
- Record 3 samples (STEP_DIV=2): `rec_pulse`, `din`=4'h3/4'hA/4'h5 at successive ticks, then `rec_pulse` → `len`=3, `done` pulse, `weout` high only during RECORD.
- Playback, macro undefined: `play_pulse` → `dout` = 3, A, 5 at 2-cycle spacing, then IDLE with one `done` pulse and `addr`=2.
- Playback, macro defined: `dout` sequence 3, A, 5, 3, A… Then `play_pulse` → IDLE, `done`=0.
- Full (DEPTH=4, STEP_DIV=1): record with `din` = 1,2,3,4,5 → auto-stop at `len`=4. Value 5 is not written; `done` pulses once.
- Simultaneous `rec_pulse` and `play_pulse` in IDLE → RECORD is entered, `len`=0, `weout`=1.

Source files
------------

// File: rtl/ram_recorder.sv
// Record/playback controller over an internal synchronous RAM, driven by one-cycle button pulses.
// Optional RAM_RECORDER_LOOP_PLAY_EN: playback wraps to address 0 instead of stopping at the end.
module ram_recorder #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 32,
  parameter int STEP_DIV = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rec_pulse,
  input  logic              play_pulse,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              weout,
  output logic              busy,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W:0]   len,
  output logic              done
);

  localparam int LEN_W = ADDR_W + 1;
  localparam int DIV_W = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECORD,
    S_PLAY
  } state_t;

  state_t             state;
  logic [DIV_W-1:0]   div_cnt;
  logic               tick;
  logic               wr_en;
  logic               last_addr;
  logic               len_full;
  logic [DATA_W-1:0]  mem [DEPTH];

  assign tick      = (div_cnt == DIV_W'(STEP_DIV - 1));
  assign wr_en     = (state == S_RECORD) && tick;
  assign last_addr = ({1'b0, addr} == (len - LEN_W'(1)));
  // The sample written on this tick is the one that fills the RAM.
  assign len_full  = ((len + LEN_W'(1)) == LEN_W'(DEPTH));

  // NOTE: the RAM has no reset so it maps onto block/distributed RAM; len
  // going to 0 on reset is what makes stale contents unreachable.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[addr] <= din;
    end
  end

  // NOTE: every register here uses <=, so all branches see the pre-edge
  // values of addr/len/div_cnt regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      div_cnt <= '0;
      dout    <= '0;
      weout   <= 1'b0;
      busy    <= 1'b0;
      addr    <= '0;
      len     <= '0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (rec_pulse) begin
            state   <= S_RECORD;
            div_cnt <= '0;
            addr    <= '0;
            len     <= '0;
            weout   <= 1'b1;
            busy    <= 1'b1;
          end else if (play_pulse && (len != '0)) begin
            state   <= S_PLAY;
            div_cnt <= '0;
            addr    <= '0;
            busy    <= 1'b1;
          end
        end

        S_RECORD: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (tick) begin
            addr <= addr + ADDR_W'(1);
            len  <= len + LEN_W'(1);
          end
          // A stop pulse on a tick edge still keeps that tick's write.
          if (rec_pulse || (tick && len_full)) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            weout   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end

        S_PLAY: begin
          div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
          if (play_pulse) begin
            state   <= S_IDLE;
            div_cnt <= '0;
            busy    <= 1'b0;
          end else if (tick) begin
            dout <= mem[addr];
            if (last_addr) begin
`ifdef RAM_RECORDER_LOOP_PLAY_EN
              addr <= '0;
`else
              state   <= S_IDLE;
              div_cnt <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
`endif
            end else begin
              addr <= addr + ADDR_W'(1);
            end
          end
        end

        default: begin
          state   <= S_IDLE;
          div_cnt <= '0;
          weout   <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_recorder.sv
// Directed bench for ram_recorder: one DUT at STEP_DIV=2/DEPTH=32, one at STEP_DIV=1/DEPTH=4.
// Observed state is packed as {dout, weout, busy, addr, len, done} (18 bits).
module tb_ram_recorder;

  logic       clk;
  logic       rst_n;
  logic       a_rec, a_play, b_rec, b_play;
  logic [3:0] a_din, b_din;
  logic [3:0] a_dout, b_dout;
  logic       a_weout, b_weout, a_busy, b_busy, a_done, b_done;
  logic [4:0] a_addr, b_addr;
  logic [5:0] a_len, b_len;
  logic [17:0] a_obs, b_obs, exp;
  int tests;
  int fails;

  assign a_obs = {a_dout, a_weout, a_busy, a_addr, a_len, a_done};
  assign b_obs = {b_dout, b_weout, b_busy, b_addr, b_len, b_done};

  ram_recorder #(.DATA_W(4), .ADDR_W(5), .DEPTH(32), .STEP_DIV(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .rec_pulse(a_rec), .play_pulse(a_play), .din(a_din),
    .dout(a_dout), .weout(a_weout), .busy(a_busy), .addr(a_addr), .len(a_len), .done(a_done)
  );

  ram_recorder #(.DATA_W(4), .ADDR_W(5), .DEPTH(4), .STEP_DIV(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .rec_pulse(b_rec), .play_pulse(b_play), .din(b_din),
    .dout(b_dout), .weout(b_weout), .busy(b_busy), .addr(b_addr), .len(b_len), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    step(1);
    exp = 18'h0;
    if (a_obs !== exp) begin fails++; $display("FAIL reset_a: got %h want %h", a_obs, exp); end
    tests++;
    if (b_obs !== exp) begin fails++; $display("FAIL reset_b: got %h want %h", b_obs, exp); end
    tests++;
    #3 rst_n = 1'b1;
    step(1);
  endtask

  task automatic test_play_empty;
    a_play = 1'b1;
    step(1);
    a_play = 1'b0;
    exp = 18'h0;
    if (a_obs !== exp) begin fails++; $display("FAIL play_empty: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    if (a_busy !== 1'b0) begin fails++; $display("FAIL play_empty_busy: got %b want 0", a_busy); end
    tests++;
  endtask

  task automatic test_simultaneous;
    a_rec = 1'b1; a_play = 1'b1;
    step(1);
    a_rec = 1'b0; a_play = 1'b0;
    exp = {4'h0, 1'b1, 1'b1, 5'd0, 6'd0, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL simul_enter: got %h want %h", a_obs, exp); end
    tests++;
    a_rec = 1'b1;
    step(1);
    a_rec = 1'b0;
    exp = {4'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1};
    if (a_obs !== exp) begin fails++; $display("FAIL simul_stop: got %h want %h", a_obs, exp); end
    tests++;
    step(1);
  endtask

  task automatic test_record3;
    a_din = 4'h3; a_rec = 1'b1;
    step(1);
    a_rec = 1'b0;
    exp = {4'h0, 1'b1, 1'b1, 5'd0, 6'd0, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_enter: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    exp = {4'h0, 1'b1, 1'b1, 5'd1, 6'd1, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_s1: got %h want %h", a_obs, exp); end
    tests++;
    a_din = 4'hA;
    step(2);
    exp = {4'h0, 1'b1, 1'b1, 5'd2, 6'd2, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_s2: got %h want %h", a_obs, exp); end
    tests++;
    a_din = 4'h5;
    step(2);
    exp = {4'h0, 1'b1, 1'b1, 5'd3, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_s3: got %h want %h", a_obs, exp); end
    tests++;
    a_din = 4'hF; a_rec = 1'b1;
    step(1);
    a_rec = 1'b0;
    exp = {4'h0, 1'b0, 1'b0, 5'd3, 6'd3, 1'b1};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_stop: got %h want %h", a_obs, exp); end
    tests++;
    step(1);
    exp = {4'h0, 1'b0, 1'b0, 5'd3, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL rec_done_clr: got %h want %h", a_obs, exp); end
    tests++;
  endtask

  task automatic test_playback;
    a_play = 1'b1;
    step(1);
    a_play = 1'b0;
    exp = {4'h0, 1'b0, 1'b1, 5'd0, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_enter: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    exp = {4'h3, 1'b0, 1'b1, 5'd1, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_s0: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    exp = {4'hA, 1'b0, 1'b1, 5'd2, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_s1: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
`ifdef RAM_RECORDER_LOOP_PLAY_EN
    exp = {4'h5, 1'b0, 1'b1, 5'd0, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_wrap: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    exp = {4'h3, 1'b0, 1'b1, 5'd1, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_loop_s0: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    exp = {4'hA, 1'b0, 1'b1, 5'd2, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_loop_s1: got %h want %h", a_obs, exp); end
    tests++;
    a_play = 1'b1;
    step(1);
    a_play = 1'b0;
    exp = {4'hA, 1'b0, 1'b0, 5'd2, 6'd3, 1'b0};
    if (a_obs !== exp) begin fails++; $display("FAIL play_loop_stop: got %h want %h", a_obs, exp); end
    tests++;
`else
    exp = {4'h5, 1'b0, 1'b0, 5'd2, 6'd3, 1'b1};
    if (a_obs !== exp) begin fails++; $display("FAIL play_end: got %h want %h", a_obs, exp); end
    tests++;
`endif
    step(1);
    exp = {a_obs[17:1], 1'b0};
    if (a_done !== 1'b0 || a_busy !== 1'b0) begin
      fails++; $display("FAIL play_after: got done=%b busy=%b want done=0 busy=0", a_done, a_busy);
    end
    tests++;
  endtask

  task automatic test_full;
    b_din = 4'h1; b_rec = 1'b1;
    step(1);
    b_rec = 1'b0;
    exp = {4'h0, 1'b1, 1'b1, 5'd0, 6'd0, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_enter: got %h want %h", b_obs, exp); end
    tests++;
    step(1);
    exp = {4'h0, 1'b1, 1'b1, 5'd1, 6'd1, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_s1: got %h want %h", b_obs, exp); end
    tests++;
    b_din = 4'h2; step(1);
    b_din = 4'h3; step(1);
    exp = {4'h0, 1'b1, 1'b1, 5'd3, 6'd3, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_s3: got %h want %h", b_obs, exp); end
    tests++;
    b_din = 4'h4; step(1);
    exp = {4'h0, 1'b0, 1'b0, 5'd4, 6'd4, 1'b1};
    if (b_obs !== exp) begin fails++; $display("FAIL full_stop: got %h want %h", b_obs, exp); end
    tests++;
    b_din = 4'h5; step(1);
    exp = {4'h0, 1'b0, 1'b0, 5'd4, 6'd4, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_after: got %h want %h", b_obs, exp); end
    tests++;
    b_play = 1'b1;
    step(1);
    b_play = 1'b0;
    step(1);
    exp = {4'h1, 1'b0, 1'b1, 5'd1, 6'd4, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_play0: got %h want %h", b_obs, exp); end
    tests++;
    step(3);
`ifdef RAM_RECORDER_LOOP_PLAY_EN
    exp = {4'h4, 1'b0, 1'b1, 5'd0, 6'd4, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_play3: got %h want %h", b_obs, exp); end
    tests++;
    step(1);
    b_play = 1'b1;
    step(1);
    b_play = 1'b0;
    exp = {4'h1, 1'b0, 1'b0, 5'd1, 6'd4, 1'b0};
    if (b_obs !== exp) begin fails++; $display("FAIL full_loop_stop: got %h want %h", b_obs, exp); end
    tests++;
`else
    exp = {4'h4, 1'b0, 1'b0, 5'd3, 6'd4, 1'b1};
    if (b_obs !== exp) begin fails++; $display("FAIL full_play3: got %h want %h", b_obs, exp); end
    tests++;
`endif
  endtask

  task automatic test_reset_mid_play;
    a_play = 1'b1;
    step(1);
    a_play = 1'b0;
    step(2);
    if (a_busy !== 1'b1) begin fails++; $display("FAIL rmp_busy: got %b want 1", a_busy); end
    tests++;
    rst_n = 1'b0;
    #1;
    exp = 18'h0;
    if (a_obs !== exp) begin fails++; $display("FAIL rmp_async: got %h want %h", a_obs, exp); end
    tests++;
    #3 rst_n = 1'b1;
    step(1);
    a_play = 1'b1;
    step(1);
    a_play = 1'b0;
    if (a_obs !== exp) begin fails++; $display("FAIL rmp_play_ign: got %h want %h", a_obs, exp); end
    tests++;
    step(2);
    if (a_busy !== 1'b0) begin fails++; $display("FAIL rmp_busy_after: got %b want 0", a_busy); end
    tests++;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst_n = 1'b0;
    a_rec = 1'b0; a_play = 1'b0; a_din = 4'h0;
    b_rec = 1'b0; b_play = 1'b0; b_din = 4'h0;
    test_reset;
    test_play_empty;
    test_simultaneous;
    test_record3;
    test_playback;
    test_full;
    test_reset_mid_play;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
